reorder_buffer: RTL and testbench

//  In-order retirement queue downstream of the reservation station and LSB result buses.

---
 rtl/reorder_buffer_pkg.sv | 19 +
 rtl/reorder_buffer.sv | 192 +++++++++++++++++++
 tb/tb_reorder_buffer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer.
//   ROB_WIDTH_BIT : log2 of the entry count (ROB_SIZE = 1 << ROB_WIDTH_BIT)
//   rob_type_e    : entry kind (register write, store, branch)
//   rob_id_t      : entry index / ROB id type
package reorder_buffer_pkg;

   localparam int ROB_WIDTH_BIT = 3;
   localparam int ROB_TYPE_BIT  = 2;
   localparam int ROB_SIZE      = 1 << ROB_WIDTH_BIT;

   typedef enum logic [ROB_TYPE_BIT-1:0] {
      ROB_TYPE_REG    = 2'd0,
      ROB_TYPE_STORE  = 2'd1,
      ROB_TYPE_BRANCH = 2'd2
   } rob_type_e;

   typedef logic [ROB_WIDTH_BIT-1:0] rob_id_t;

endpackage

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement queue.
//   Allocates a ROB id per issued instruction (tail), captures ALU (rs_*) and
//   LSB (lsb_*) result broadcasts, answers two operand-readiness queries and
//   retires at most one ready entry per cycle from the head.
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (low = hold everything)
//   issue_*        : allocation request and entry contents
//   full, tail_id  : allocation status / id of the entry issued this cycle
//   rs_*, lsb_*    : result broadcasts (ready strobe, id, value)
//   qry1_*, qry2_* : operand queries (id in, ready/value out)
//   commit_*       : registered retire pulse for REG entries, commit_store for STOREs
//   flush, flush_pc: registered mispredict pulse and restart PC
// Configuration macro: ROB_BYPASS_EN -- when defined, queries also forward a
//   same-cycle rs/lsb broadcast (rs has precedence).
// Handshake: issue_valid is taken in any active cycle where the buffer is not
//   already holding ROB_SIZE entries; full is a one-cycle advance warning that
//   the next issue must not be presented.
module reorder_buffer
   import reorder_buffer_pkg::*;
(
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     rdy_in,
   input  logic                     issue_valid,
   input  logic [ROB_TYPE_BIT-1:0]  issue_type,
   input  logic [4:0]               issue_rd,
   input  logic                     issue_ready,
   input  logic [31:0]              issue_value,
   input  logic                     issue_pred,
   input  logic [31:0]              issue_alt_pc,
   output logic                     full,
   output logic [ROB_WIDTH_BIT-1:0] tail_id,
   input  logic                     rs_ready,
   input  logic [ROB_WIDTH_BIT-1:0] rs_rob_id,
   input  logic [31:0]              rs_value,
   input  logic                     lsb_ready,
   input  logic [ROB_WIDTH_BIT-1:0] lsb_rob_id,
   input  logic [31:0]              lsb_value,
   input  logic [ROB_WIDTH_BIT-1:0] qry1_id,
   input  logic [ROB_WIDTH_BIT-1:0] qry2_id,
   output logic                     qry1_ready,
   output logic                     qry2_ready,
   output logic [31:0]              qry1_value,
   output logic [31:0]              qry2_value,
   output logic                     commit_valid,
   output logic [4:0]               commit_rd,
   output logic [31:0]              commit_value,
   output logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
   output logic                     commit_store,
   output logic                     flush,
   output logic [31:0]              flush_pc
);

   localparam logic [ROB_WIDTH_BIT:0] CNT_FULL   = {1'b1, {ROB_WIDTH_BIT{1'b0}}};
   localparam logic [ROB_WIDTH_BIT:0] CNT_ALMOST = {1'b0, {ROB_WIDTH_BIT{1'b1}}};

   rob_id_t                 head_q, tail_q;
   logic [ROB_WIDTH_BIT:0]  count_q;
   logic [ROB_SIZE-1:0]     busy_q, ready_q;
   logic [31:0]             value_q  [ROB_SIZE];
   logic [31:0]             alt_pc_q [ROB_SIZE];
   logic [4:0]              rd_q     [ROB_SIZE];
   rob_type_e               type_q   [ROB_SIZE];
   logic [ROB_SIZE-1:0]     pred_q;

   logic      is_full, retire, mispredict, issue_fire;
   rob_type_e head_type;

   assign is_full    = (count_q == CNT_FULL);
   assign head_type  = type_q[head_q];
   assign retire     = busy_q[head_q] && ready_q[head_q];
   // A branch carries its resolved direction in value bit 0.
   assign mispredict = retire && (head_type == ROB_TYPE_BRANCH) &&
                       (value_q[head_q][0] != pred_q[head_q]);
   assign issue_fire = issue_valid && !is_full;

   assign tail_id = tail_q;
   assign full    = is_full || ((count_q == CNT_ALMOST) && issue_valid && !retire);

   always_comb begin
      qry1_ready = busy_q[qry1_id] && ready_q[qry1_id];
      qry1_value = qry1_ready ? value_q[qry1_id] : 32'd0;
      qry2_ready = busy_q[qry2_id] && ready_q[qry2_id];
      qry2_value = qry2_ready ? value_q[qry2_id] : 32'd0;
`ifdef ROB_BYPASS_EN
      if (busy_q[qry1_id]) begin
         if (rs_ready && rs_rob_id == qry1_id) begin
            qry1_ready = 1'b1;
            qry1_value = rs_value;
         end else if (lsb_ready && lsb_rob_id == qry1_id) begin
            qry1_ready = 1'b1;
            qry1_value = lsb_value;
         end
      end
      if (busy_q[qry2_id]) begin
         if (rs_ready && rs_rob_id == qry2_id) begin
            qry2_ready = 1'b1;
            qry2_value = rs_value;
         end else if (lsb_ready && lsb_rob_id == qry2_id) begin
            qry2_ready = 1'b1;
            qry2_value = lsb_value;
         end
      end
`endif
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         busy_q        <= '0;
         ready_q       <= '0;
         pred_q        <= '0;
         for (int i = 0; i < ROB_SIZE; i++) begin
            value_q[i]  <= '0;
            alt_pc_q[i] <= '0;
            rd_q[i]     <= '0;
            type_q[i]   <= ROB_TYPE_REG;
         end
         commit_valid  <= 1'b0;
         commit_rd     <= '0;
         commit_value  <= '0;
         commit_rob_id <= '0;
         commit_store  <= 1'b0;
         flush         <= 1'b0;
         flush_pc      <= '0;
      end else if (rdy_in) begin
         if (mispredict) begin
            // Squash everything; any issue presented this cycle is dropped.
            busy_q       <= '0;
            ready_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            flush        <= 1'b1;
            flush_pc     <= alt_pc_q[head_q];
            commit_valid <= 1'b0;
            commit_store <= 1'b0;
         end else begin
            flush        <= 1'b0;
            commit_valid <= retire && (head_type == ROB_TYPE_REG);
            commit_store <= retire && (head_type == ROB_TYPE_STORE);
            if (retire && head_type == ROB_TYPE_REG) begin
               commit_rd     <= rd_q[head_q];
               commit_value  <= value_q[head_q];
               commit_rob_id <= head_q;
            end

            if (issue_fire) begin
               busy_q[tail_q]   <= 1'b1;
               ready_q[tail_q]  <= issue_ready;
               value_q[tail_q]  <= issue_value;
               alt_pc_q[tail_q] <= issue_alt_pc;
               rd_q[tail_q]     <= issue_rd;
               type_q[tail_q]   <= rob_type_e'(issue_type);
               pred_q[tail_q]   <= issue_pred;
               tail_q           <= tail_q + 1'b1;
            end

            // Broadcasts land on live entries and on the entry being issued now;
            // written after the issue fields so a same-cycle result wins, and rs
            // last so it wins if both buses name the same id.
            for (int i = 0; i < ROB_SIZE; i++) begin
               if ((busy_q[i] || (issue_fire && tail_q == rob_id_t'(i))) &&
                   lsb_ready && lsb_rob_id == rob_id_t'(i)) begin
                  ready_q[i] <= 1'b1;
                  value_q[i] <= lsb_value;
               end
               if ((busy_q[i] || (issue_fire && tail_q == rob_id_t'(i))) &&
                   rs_ready && rs_rob_id == rob_id_t'(i)) begin
                  ready_q[i] <= 1'b1;
                  value_q[i] <= rs_value;
               end
            end

            if (retire) begin
               busy_q[head_q]  <= 1'b0;
               ready_q[head_q] <= 1'b0;
               head_q          <= head_q + 1'b1;
            end

            case ({issue_fire, retire})
               2'b10:   count_q <= count_q + 1'b1;
               2'b01:   count_q <= count_q - 1'b1;
               default: count_q <= count_q;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: randomized and directed stimulus for reorder_buffer,
// checked against a queue-based behavioural model of the ROB.
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   localparam int W    = ROB_WIDTH_BIT;
   localparam int SIZE = 1 << W;
`ifdef ROB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk_in, rst_in, rdy_in;
   logic          issue_valid, issue_ready, issue_pred;
   logic [1:0]    issue_type;
   logic [4:0]    issue_rd;
   logic [31:0]   issue_value, issue_alt_pc;
   logic          full;
   logic [W-1:0]  tail_id;
   logic          rs_ready, lsb_ready;
   logic [W-1:0]  rs_rob_id, lsb_rob_id, qry1_id, qry2_id;
   logic [31:0]   rs_value, lsb_value;
   logic          qry1_ready, qry2_ready;
   logic [31:0]   qry1_value, qry2_value;
   logic          commit_valid, commit_store, flush;
   logic [4:0]    commit_rd;
   logic [31:0]   commit_value, flush_pc;
   logic [W-1:0]  commit_rob_id;

   reorder_buffer dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
      .issue_ready(issue_ready), .issue_value(issue_value), .issue_pred(issue_pred),
      .issue_alt_pc(issue_alt_pc), .full(full), .tail_id(tail_id),
      .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_value(rs_value),
      .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
      .qry1_id(qry1_id), .qry2_id(qry2_id), .qry1_ready(qry1_ready),
      .qry2_ready(qry2_ready), .qry1_value(qry1_value), .qry2_value(qry2_value),
      .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
      .commit_rob_id(commit_rob_id), .commit_store(commit_store),
      .flush(flush), .flush_pc(flush_pc)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   // ---------------- reference model ----------------
   typedef struct {
      int          id;
      int          typ;
      int          rd;
      bit          rdy;
      logic [31:0] val;
      bit          pred;
      logic [31:0] alt;
   } m_entry_t;

   m_entry_t    m_q[$];        // live entries, oldest first
   int          m_head;
   logic [31:0] exp_q[$];      // expected commit values, in retire order
   bit          e_cv, e_cs, e_fl;
   int          e_rd, e_id;
   logic [31:0] e_val, e_fpc;

   int n_vec, n_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void m_query(input int id, output bit r, output logic [31:0] v);
      r = 1'b0;
      v = 32'd0;
      foreach (m_q[k]) begin
         if (m_q[k].id == id) begin
            r = m_q[k].rdy;
            v = r ? m_q[k].val : 32'd0;
            if (BYP && lsb_ready && int'(lsb_rob_id) == id) begin r = 1'b1; v = lsb_value; end
            if (BYP && rs_ready && int'(rs_rob_id) == id) begin r = 1'b1; v = rs_value; end
         end
      end
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_idle();
      rdy_in = 1'b1; issue_valid = 1'b0; issue_type = 2'd0; issue_rd = 5'd0;
      issue_ready = 1'b0; issue_value = 32'd0; issue_pred = 1'b0; issue_alt_pc = 32'd0;
      rs_ready = 1'b0; rs_rob_id = '0; rs_value = 32'd0;
      lsb_ready = 1'b0; lsb_rob_id = '0; lsb_value = 32'd0;
      qry1_id = '0; qry2_id = '0;
   endtask

   task automatic set_issue(input int typ, input int rd, input bit rdy, input logic [31:0] val,
                            input bit pred, input logic [31:0] alt);
      issue_valid = 1'b1; issue_type = 2'(typ); issue_rd = 5'(rd); issue_ready = rdy;
      issue_value = val; issue_pred = pred; issue_alt_pc = alt;
   endtask

   task automatic do_reset();
      #2 rst_in = 1'b1;
      #1;
      check("rst_commit_valid", 32'(commit_valid), 32'd0);
      check("rst_commit_store", 32'(commit_store), 32'd0);
      check("rst_flush", 32'(flush), 32'd0);
      check("rst_flush_pc", flush_pc, 32'd0);
      check("rst_commit_value", commit_value, 32'd0);
      check("rst_tail_id", 32'(tail_id), 32'd0);
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      m_q.delete(); exp_q.delete(); m_head = 0;
      e_cv = 0; e_cs = 0; e_fl = 0; e_rd = 0; e_id = 0; e_val = 0; e_fpc = 0;
      set_idle();
   endtask

   // One clock: check combinational outputs, advance model, check registered outputs.
   task automatic step();
      int          tail;
      bit          ret, fl, r;
      logic [31:0] v;
      m_entry_t    e, n;
      #1;
      tail = (m_head + m_q.size()) % SIZE;
      ret  = (m_q.size() > 0) && m_q[0].rdy;
      check("tail_id", 32'(tail_id), 32'(tail));
      check("full", 32'(full), 32'(m_q.size() == SIZE || (m_q.size() == SIZE-1 && issue_valid && !ret)));
      m_query(int'(qry1_id), r, v);
      check("qry1_ready", 32'(qry1_ready), 32'(r));
      check("qry1_value", qry1_value, v);
      m_query(int'(qry2_id), r, v);
      check("qry2_ready", 32'(qry2_ready), 32'(r));
      check("qry2_value", qry2_value, v);

      if (rdy_in) begin
         e_cv = 0; e_cs = 0; e_fl = 0; fl = 0;
         if (ret) begin
            e = m_q[0];
            if (e.typ == 0) begin
               e_cv = 1; e_rd = e.rd; e_val = e.val; e_id = m_head;
               exp_q.push_back(e.val);
            end else if (e.typ == 1) e_cs = 1;
            else if (e.val[0] != e.pred) fl = 1;
         end
         if (fl) begin
            e_fl = 1; e_fpc = e.alt; m_q.delete(); m_head = 0;
         end else begin
            foreach (m_q[k]) begin
               if (lsb_ready && int'(lsb_rob_id) == m_q[k].id) begin m_q[k].rdy = 1; m_q[k].val = lsb_value; end
               if (rs_ready && int'(rs_rob_id) == m_q[k].id) begin m_q[k].rdy = 1; m_q[k].val = rs_value; end
            end
            if (issue_valid && m_q.size() < SIZE) begin
               n.id = tail; n.typ = int'(issue_type); n.rd = int'(issue_rd); n.rdy = issue_ready;
               n.val = issue_value; n.pred = issue_pred; n.alt = issue_alt_pc;
               if (lsb_ready && int'(lsb_rob_id) == tail) begin n.rdy = 1; n.val = lsb_value; end
               if (rs_ready && int'(rs_rob_id) == tail) begin n.rdy = 1; n.val = rs_value; end
               m_q.push_back(n);
            end
            if (ret) begin
               void'(m_q.pop_front());
               m_head = (m_head + 1) % SIZE;
            end
         end
      end

      @(posedge clk_in); #1;
      check("commit_valid", 32'(commit_valid), 32'(e_cv));
      check("commit_store", 32'(commit_store), 32'(e_cs));
      check("flush", 32'(flush), 32'(e_fl));
      check("commit_rd", 32'(commit_rd), 32'(e_rd));
      check("commit_value", commit_value, e_val);
      check("commit_rob_id", 32'(commit_rob_id), 32'(e_id));
      check("flush_pc", flush_pc, e_fpc);
      // scoreboard: every fresh commit must match the next expected value
      if (rdy_in && commit_valid) begin
         if (exp_q.size() == 0) check("sb_unexpected_commit", 32'd1, 32'd0);
         else check("sb_commit", commit_value, exp_q.pop_front());
      end
   endtask

   task automatic rand_inputs();
      rdy_in      = ($urandom_range(0, 9) != 0);
      issue_valid = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 9))
         0, 1, 2, 3, 4, 5: issue_type = 2'd0;
         6, 7:             issue_type = 2'd1;
         default:          issue_type = 2'd2;
      endcase
      issue_rd     = 5'($urandom_range(0, 31));
      issue_ready  = ($urandom_range(0, 3) == 0);
      issue_value  = $urandom;
      issue_pred   = 1'($urandom_range(0, 1));
      issue_alt_pc = $urandom;
      rs_ready  = ($urandom_range(0, 1) == 1);
      lsb_ready = ($urandom_range(0, 2) == 0);
      if (m_q.size() > 0 && $urandom_range(0, 3) != 0)
         rs_rob_id = W'(m_q[$urandom_range(0, m_q.size()-1)].id);
      else
         rs_rob_id = W'($urandom_range(0, SIZE-1));
      if (m_q.size() > 0 && $urandom_range(0, 3) != 0)
         lsb_rob_id = W'(m_q[$urandom_range(0, m_q.size()-1)].id);
      else
         lsb_rob_id = W'($urandom_range(0, SIZE-1));
      if (rs_ready && lsb_ready && rs_rob_id == lsb_rob_id) lsb_ready = 1'b0;
      rs_value  = $urandom;
      lsb_value = $urandom;
      qry1_id   = W'($urandom_range(0, SIZE-1));
      qry2_id   = W'($urandom_range(0, SIZE-1));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_vec = 0; n_err = 0;
      rst_in = 1'b0;
      set_idle();
      #1;
      do_reset();

      // 1: ready REG retires straight away
      set_issue(0, 5, 1, 32'h11, 0, 0);
      step();
      set_idle();
      step();
      check("t1_commit_valid", 32'(commit_valid), 32'd1);
      check("t1_commit_rd", 32'(commit_rd), 32'd5);
      check("t1_commit_value", commit_value, 32'h11);
      check("t1_commit_rob_id", 32'(commit_rob_id), 32'd0);

      // 2: fill, overflow attempt, drain one
      do_reset();
      for (int i = 0; i < SIZE; i++) begin
         set_issue(0, i + 1, 0, 0, 0, 0);
         step();
      end
      check("t2_full", 32'(full), 32'd1);
      check("t2_tail_wrap", 32'(tail_id), 32'd0);
      set_issue(0, 9, 1, 32'h99, 0, 0);
      step();
      set_idle();
      rs_ready = 1'b1; rs_rob_id = '0; rs_value = 32'd7;
      step();
      set_idle();
      step();
      check("t2_commit_value", commit_value, 32'd7);
      check("t2_full_drop", 32'(full), 32'd0);

      // 3: out-of-order writeback, in-order commit
      do_reset();
      set_issue(0, 1, 0, 0, 0, 0); step();
      set_issue(0, 2, 0, 0, 0, 0); step();
      set_idle(); rs_ready = 1'b1; rs_rob_id = W'(1); rs_value = 32'hA; step();
      set_idle(); lsb_ready = 1'b1; lsb_rob_id = W'(0); lsb_value = 32'hB; step();
      set_idle(); step();
      check("t3_first", commit_value, 32'hB);
      step();
      check("t3_second", commit_value, 32'hA);
      check("t3_second_id", 32'(commit_rob_id), 32'd1);

      // 4: mispredicted branch squashes younger entries; same-cycle issue dropped
      do_reset();
      set_issue(2, 0, 0, 0, 1, 32'h100); step();
      set_issue(0, 3, 1, 32'h33, 0, 0); step();
      set_issue(0, 4, 1, 32'h44, 0, 0); step();
      set_idle(); rs_ready = 1'b1; rs_rob_id = '0; rs_value = 32'd0; step();
      set_idle(); set_issue(0, 6, 1, 32'h66, 0, 0); step();
      check("t4_flush", 32'(flush), 32'd1);
      check("t4_flush_pc", flush_pc, 32'h100);
      check("t4_tail_reset", 32'(tail_id), 32'd0);
      set_idle();
      for (int i = 0; i < 3; i++) step();

      // 5: store retires via commit_store only
      do_reset();
      set_issue(1, 0, 0, 0, 0, 0); step();
      set_idle(); lsb_ready = 1'b1; lsb_rob_id = '0; lsb_value = 32'h5; step();
      set_idle(); step();
      check("t5_commit_store", 32'(commit_store), 32'd1);
      check("t5_commit_valid", 32'(commit_valid), 32'd0);

      // 6: query sees a same-cycle broadcast only with bypass
      do_reset();
      for (int i = 0; i < 3; i++) begin
         set_issue(0, i + 1, 0, 0, 0, 0);
         step();
      end
      set_idle(); qry1_id = W'(2); rs_ready = 1'b1; rs_rob_id = W'(2); rs_value = 32'h55;
      #1;
      check("t6_qry_ready", 32'(qry1_ready), 32'(BYP));
      check("t6_qry_value", qry1_value, BYP ? 32'h55 : 32'd0);
      step();
      set_idle(); qry1_id = W'(2);
      step();

      // random traffic, with an asynchronous reset in the middle
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) do_reset();
         rand_inputs();
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
